// File: rtl/seg_pattern_decoder_pkg.sv
// Shared types and glyph table for the 7-segment receive decoder.
// Optional blank-glyph acceptance is selected with SEG_BLANK_OK_EN.
package seg_decode_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, indexed by the nibble they encode
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic {
    SEG_SETTLE,
    SEG_LOCKED
  } seg_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] nib;
  } seg_lut_t;

endpackage

// File: rtl/seg_pattern_decoder_if.sv
// Segment bus plus decode results between display path and decoder.
// Built the same way whether or not SEG_BLANK_OK_EN is defined.
interface seg_pattern_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int SEL_W = $clog2(NUM_DIGITS);

  logic [6:0]              seg_in;
  logic [SEL_W-1:0]        digit_sel;
  logic                    dec_valid;
  logic                    dec_err;
  logic [SEL_W-1:0]        dec_digit;
  logic [3:0]              dec_nibble;
  logic [4*NUM_DIGITS-1:0] digit_val;
  logic [NUM_DIGITS-1:0]   digit_ok;

  modport master (
    output seg_in, digit_sel,
    input  dec_valid, dec_err, dec_digit,
    input  dec_nibble, digit_val, digit_ok
  );

  modport slave (
    input  seg_in, digit_sel,
    output dec_valid, dec_err, dec_digit,
    output dec_nibble, digit_val, digit_ok
  );

endinterface

// File: rtl/seg_pattern_decoder_lut.sv
// Combinational active-low glyph to hex nibble lookup.
// Unaffected by SEG_BLANK_OK_EN; blank handling lives in the top.
module seg_pattern_lut
  import seg_decode_pkg::*;
(
  input  logic [6:0] seg,
  output seg_lut_t   res
);

  always_comb begin
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPH[i]) begin
        res.hit = 1'b1;
        res.nib = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Glitch-filtered decoder of the multiplexed 7-segment bus.
// Define SEG_BLANK_OK_EN to accept 7'h7F as a silent blank.
module seg_pattern_decoder
  import seg_decode_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input logic                  clk,
  input logic                  reset,
  seg_pattern_decoder_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int SMP_W = SEL_W + 7;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CYCLES);

  seg_state_e              state_q;
  logic [SMP_W-1:0]        smp, smp_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    restart, accept;
  logic                    in_rng, blank, good, bad;
  seg_lut_t                lut;
  logic                    valid_q, err_q;
  logic [SEL_W-1:0]        digit_q;
  logic [3:0]              nib_q;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   ok_q;

  seg_pattern_lut u_lut (
    .seg (bus.seg_in),
    .res (lut)
  );

  assign smp     = {bus.digit_sel, bus.seg_in};
  assign restart = (cnt_q == '0) || (smp != smp_q);
  assign cnt_d   = restart          ? CNT_W'(1) :
                   (cnt_q == CNT_MAX) ? CNT_MAX :
                   cnt_q + 1'b1;

  // A fresh run may re-accept at once when only one cycle is needed
  assign accept = (cnt_d == CNT_MAX) &&
                  (state_q == SEG_SETTLE || restart);

  assign in_rng = int'(bus.digit_sel) < NUM_DIGITS;
`ifdef SEG_BLANK_OK_EN
  assign blank = (bus.seg_in == SEG_BLANK);
`else
  assign blank = 1'b0;
`endif
  assign good = in_rng && lut.hit;
  assign bad  = !in_rng || (!lut.hit && !blank);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEG_SETTLE;
      smp_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      digit_q <= '0;
      nib_q   <= '0;
      val_q   <= '0;
      ok_q    <= '0;
    end else begin
      smp_q   <= smp;
      cnt_q   <= cnt_d;
      valid_q <= accept && good;
      err_q   <= accept && bad;
      if (accept) begin
        state_q <= SEG_LOCKED;
      end else if (restart) begin
        state_q <= SEG_SETTLE;
      end
      if (accept) begin
        digit_q <= bus.digit_sel;
        if (good) begin
          nib_q <= lut.nib;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (in_rng && bus.digit_sel == SEL_W'(i)) begin
            ok_q[i] <= good;
            if (good) begin
              val_q[4*i +: 4] <= lut.nib;
            end
          end
        end
      end
    end
  end

  assign bus.dec_valid  = valid_q;
  assign bus.dec_err    = err_q;
  assign bus.dec_digit  = digit_q;
  assign bus.dec_nibble = nib_q;
  assign bus.digit_val  = val_q;
  assign bus.digit_ok   = ok_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Scoreboard bench for seg_pattern_decoder with a run-length reference model.
// Honours SEG_BLANK_OK_EN in the same way as the design build.
module tb_seg_pattern_decoder;

  localparam int ND = 4;
  localparam int SC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_pattern_decoder_if #(.NUM_DIGITS(ND)) bus();

  seg_pattern_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit err;
    int digit;
    int nib;
  } rep_t;

  rep_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  int   n_err   = 0;

  int hex_code [16] = '{
    'h01, 'h4F, 'h12, 'h06, 'h4C, 'h24, 'h20, 'h0F,
    'h00, 'h04, 'h08, 'h60, 'h31, 'h42, 'h30, 'h38
  };

  int m_val [ND];
  int m_ok  [ND];
  int m_digit = 0;
  int m_nib   = 0;
  int run     = 0;
  int last    = 0;
  bit rst_q   = 1'b1;

  function automatic int decode(int seg);
    for (int i = 0; i < 16; i++)
      if (hex_code[i] == seg) return i;
    return -1;
  endfunction

  function automatic bit blank_ok(int seg);
`ifdef SEG_BLANK_OK_EN
    return seg == 'h7F;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: a sample is reported when it has been seen for exactly SC
  // consecutive cycles since the last change or reset.
  initial begin
    for (int i = 0; i < ND; i++) begin
      m_val[i] = 0;
      m_ok[i]  = 0;
    end
    forever begin
      @(posedge clk);
      rst_q = reset;
      if (reset) begin
        run = 0;
        m_digit = 0;
        m_nib = 0;
        for (int i = 0; i < ND; i++) begin
          m_val[i] = 0;
          m_ok[i]  = 0;
        end
      end else begin
        int s, seg, sl, n;
        s = int'({bus.digit_sel, bus.seg_in});
        if (run > 0 && s == last) run++;
        else run = 1;
        last = s;
        if (run == SC) begin
          seg = s % 128;
          sl  = s / 128;
          n   = decode(seg);
          m_digit = sl;
          if (n >= 0) begin
            q.push_back('{1'b0, sl, n});
            m_nib = n;
            m_val[sl] = n;
            m_ok[sl]  = 1;
          end else begin
            m_ok[sl] = 0;
            if (!blank_ok(seg))
              q.push_back('{1'b1, sl, m_nib});
          end
        end
      end
    end
  end

  // Monitor: every report must match the head of the queue in its cycle
  initial begin
    forever begin
      int ev, eo;
      rep_t r;
      @(negedge clk);
      if (rst_q) begin
        check("rst_valid", int'(bus.dec_valid), 0);
        check("rst_err", int'(bus.dec_err), 0);
      end
      if (bus.dec_valid || bus.dec_err) begin
        n_valid += int'(bus.dec_valid);
        n_err   += int'(bus.dec_err);
        check("pulse_excl",
              int'(bus.dec_valid && bus.dec_err), 0);
        if (q.size() == 0) begin
          check("unexpected_report", 1, 0);
        end else begin
          r = q.pop_front();
          check("rep_err", int'(bus.dec_err), int'(r.err));
          check("rep_digit", int'(bus.dec_digit), r.digit);
          check("rep_nibble", int'(bus.dec_nibble), r.nib);
        end
      end else if (q.size() != 0) begin
        r = q.pop_front();
        check("missing_report", 0, 1);
      end
      ev = 0;
      eo = 0;
      for (int i = 0; i < ND; i++) begin
        ev |= m_val[i] << (4 * i);
        eo |= m_ok[i] << i;
      end
      check("digit_val", int'(bus.digit_val), ev);
      check("digit_ok", int'(bus.digit_ok), eo);
      check("dec_digit", int'(bus.dec_digit), m_digit);
      check("dec_nibble", int'(bus.dec_nibble), m_nib);
    end
  end

  task automatic hold(int seg, int sel, int n);
    bus.seg_in    = 7'(seg);
    bus.digit_sel = 2'(sel);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0, e0, seg, sel, k;
    bus.seg_in    = 7'h7E;
    bus.digit_sel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: glyph 2 on slot 1
    hold('h12, 1, 4);
    #1;
    check("t1_val", int'(bus.digit_val[7:4]), 2);
    check("t1_ok", int'(bus.digit_ok), 'b0010);

    // 2: short glitch then stable 3
    v0 = n_valid;
    hold('h24, 0, 2);
    hold('h06, 0, 5);
    #1;
    check("t2_count", n_valid - v0, 1);

    // 3: non-hex on slot 2
    hold('h4C, 2, 4);
    e0 = n_err;
    hold('h7E, 2, 4);
    #1;
    check("t3_err", n_err - e0, 1);
    check("t3_ok2", int'(bus.digit_ok[2]), 0);
    check("t3_val2", int'(bus.digit_val[11:8]), 4);

    // 4: full sweep
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 16; i++) hold(hex_code[i], i % 4, 4);
    #1;
    check("t4_valid", n_valid - v0, 16);
    check("t4_err", n_err - e0, 0);

    // 5: reset in the middle of a run
    hold('h20, 3, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold('h20, 3, 5);

    // 6: blank pattern
    hold('h7F, 3, 5);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      k = $urandom_range(0, 9);
      if (k < 5) seg = hex_code[$urandom_range(0, 15)];
      else if (k < 7) seg = $urandom_range(0, 127);
      else if (k < 8) seg = 'h7F;
      else seg = int'(bus.seg_in);
      sel = $urandom_range(0, ND - 1);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        hold(seg, sel, $urandom_range(1, 2));
        reset = 1'b0;
      end
      hold(seg, sel, $urandom_range(1, 6));
    end

    hold('h01, 0, 6);
    #1;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
